// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Six-digit 7-segment scan controller with one shared hex decoder;
//            optional blinking enabled by defining SEG_SCAN_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg_scan_ctrl #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic [5:0] dig_en,
    input  logic [5:0] blink_mask,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5
);

    localparam logic [6:0] c_BLANK   = 7'b1111111;
    localparam logic [2:0] c_LAST    = 3'd5;

    logic [3:0] r_d [6];
    logic [6:0] r_hex [6];
    logic [2:0] r_ptr;
    logic [2:0] r_pidx;
    logic       r_pend;

    logic [2:0] w_slot;
    logic [3:0] w_digit;
    logic [6:0] w_seg;
    logic       w_blank;
    logic       w_wr_acc;

    // A pending write steals one slot so its digit refreshes immediately.
    assign w_slot   = r_pend ? r_pidx : r_ptr;
    assign w_digit  = r_d[w_slot];
    assign wr_ready = !r_pend;
    assign w_wr_acc = wr_en && !r_pend && (wr_idx <= c_LAST);

    always_comb begin
        w_seg = c_BLANK;
        case (w_digit)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            4'hF: w_seg = 7'b0001110;
            default: w_seg = c_BLANK;
        endcase
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_phase;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= !r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank = !dig_en[w_slot] || (blink_mask[w_slot] && r_phase);
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (^blink_mask) ^ (BLINK_DIV > 0);
    assign w_blank      = !dig_en[w_slot];
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 6; i++) begin
                r_d[i]   <= 4'h0;
                r_hex[i] <= c_BLANK;
            end
            r_ptr  <= 3'd0;
            r_pidx <= 3'd0;
            r_pend <= 1'b0;
        end else begin
            r_hex[w_slot] <= w_blank ? c_BLANK : w_seg;
            if (r_pend) begin
                r_pend <= 1'b0;
            end else begin
                r_ptr <= (r_ptr == c_LAST) ? 3'd0 : r_ptr + 3'd1;
                if (w_wr_acc) begin
                    r_d[wr_idx] <= wr_data;
                    r_pend      <= 1'b1;
                    r_pidx      <= wr_idx;
                end
            end
        end
    end

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];

endmodule

`default_nettype wire
